// File: rtl/direction_batch_arbiter.sv
// Round-robin batch arbiter: grants one direction-vector source at a time,
// forwards exactly QUANTITY vectors to the shared aggregator, then collects
// the aggregator's two-bin result, tags it with the source index and hands
// it downstream before the next source may be granted.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no batch open; pick next valid source round-robin
// STREAM      | granted source wired through to aggregator, counting xfers
// WAIT_RESULT | batch complete; ack and capture aggregator result
// OUTPUT      | tagged result presented until downstream accepts
module direction_batch_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QUANTITY   = 199
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [NUM_SRC-1:0]                   src_valid_in,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]        src_direction_in,
  input  logic [NUM_SRC*(DATA_WIDTH/2)-1:0]    src_magnitude_in,
  output logic [NUM_SRC-1:0]                   src_ready_out,
  output logic                                 agg_valid_out,
  output logic [DATA_WIDTH-1:0]                agg_direction_out,
  output logic [DATA_WIDTH/2-1:0]              agg_magnitude_out,
  input  logic                                 agg_ready_in,
  input  logic                                 agg_result_valid_in,
  input  logic signed [23:0]                   agg_bin0_in,
  input  logic signed [23:0]                   agg_bin1_in,
  output logic                                 agg_ack_out,
  output logic                                 res_valid_out,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] res_src_out,
  output logic signed [23:0]                   res_bin0_out,
  output logic signed [23:0]                   res_bin1_out,
  output logic                                 res_dir_out,
  input  logic                                 res_ready_in
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int MAG_W = DATA_WIDTH / 2;
  localparam int CNT_W = $clog2(QUANTITY + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  // Reset value makes source 0 the first winner of the round-robin search.
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTITY - 1);

  logic [1:0]        state;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  last_grant;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              stream;
  logic              xfer;
  logic              rr_found;
  logic [SRC_W-1:0]  rr_idx;
  logic [SRC_W-1:0]  rr_grant;
  logic [SRC_W-1:0]  res_src_q;
  logic signed [23:0] res_bin0_q;
  logic signed [23:0] res_bin1_q;
  logic              res_dir_q;

  assign stream = (state == ST_STREAM);
  assign xfer   = agg_valid_out && agg_ready_in;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_grant = last_grant;
    for (int i = 1; i <= NUM_SRC; i++) begin
      rr_idx = SRC_W'((int'(last_grant) + i) % NUM_SRC);
      if (!rr_found && src_valid_in[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  // Granted source is wired straight through only while streaming.
  always_comb begin
    src_ready_out     = '0;
    agg_valid_out     = 1'b0;
    agg_direction_out = '0;
    agg_magnitude_out = '0;
    if (stream) begin
      agg_valid_out         = src_valid_in[grant];
      agg_direction_out     = src_direction_in[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      agg_magnitude_out     = src_magnitude_in[int'(grant)*MAG_W +: MAG_W];
      src_ready_out[grant]  = agg_ready_in;
    end
  end

  assign agg_ack_out   = (state == ST_WAIT) && agg_result_valid_in;
  assign res_valid_out = (state == ST_OUTPUT);
  assign res_src_out   = res_src_q;
  assign res_bin0_out  = res_bin0_q;
  assign res_bin1_out  = res_bin1_q;
  assign res_dir_out   = res_dir_q;

  // Batch sequencing, transfer counting and result capture.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_RST;
      xfer_cnt   <= '0;
      res_src_q  <= '0;
      res_bin0_q <= '0;
      res_bin1_q <= '0;
      res_dir_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_found) begin
            grant <= rr_grant;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (xfer_cnt == CNT_LAST) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (agg_result_valid_in) begin
            res_src_q  <= grant;
            res_bin0_q <= agg_bin0_in;
            res_bin1_q <= agg_bin1_in;
            res_dir_q  <= (agg_bin1_in > agg_bin0_in);
            state      <= ST_OUTPUT;
          end
        end
        default: begin
          if (res_ready_in) begin
            last_grant <= grant;
            xfer_cnt   <= '0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
